// File: rtl/kiwi_cic_pkg.sv
// rtl/kiwi_cic_pkg.sv - shared constants and rate helpers for the CIC filters
package kiwi_cic_pkg;

    localparam int MD = 18;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Bits of DC gain that an N-stage interpolator at rate R adds above the input width
    function automatic int growth_r(input int n, input int r);
        return (n - 1) * clog2(r);
    endfunction

    function automatic logic is_legal_r(input logic [MD-1:0] r, input int rmax);
        return (r != '0) && ((r & (r - MD'(1))) == '0) && (int'(r) <= rmax);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// rtl/cic_comb_stage.sv - one D=1 comb with a clock-enabled delay register
module cic_comb_stage #(
    parameter int WIDTH = 25
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    enable,
    input  logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] y
);

    logic signed [WIDTH-1:0] delay_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            delay_q <= '0;
        end else if (clear) begin
            delay_q <= '0;
        end else if (enable) begin
            delay_q <= x;
        end
    end

    assign y = x - delay_q;

endmodule

// File: rtl/cic_interp_var.sv
// rtl/cic_interp_var.sv - fixed/variable power-of-two CIC interpolator, gain normalized
// Optional sticky underrun detection: CIC_INTERP_UNDERRUN_EN
import kiwi_cic_pkg::*;

module cic_interp_var #(
    parameter int STAGES        = 3,
    parameter int INTERPOLATION = -8,
    parameter int IN_WIDTH      = 16,
    parameter int GROWTH        = 9,
    parameter int OUT_WIDTH     = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [MD-1:0]               interpolation,
    input  logic                        in_strobe,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic                        in_ready,
    input  logic                        rate_strobe,
    output logic                        out_strobe,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        underrun
);

    localparam int         ACC_WIDTH = IN_WIDTH + GROWTH;
    localparam bit         VARIABLE  = INTERPOLATION < 0;
    localparam int         RMAX      = VARIABLE ? -INTERPOLATION : INTERPOLATION;
    localparam int         KMAX      = clog2(RMAX);
    localparam int         PW        = (KMAX > 0) ? KMAX : 1;
    localparam logic [4:0] K_FIXED   = 5'(clog2(RMAX));

    logic [MD-1:0]                interp_q;
    logic [4:0]                   k_q;
    logic [4:0]                   k_cur;
    logic                         clr;
    logic                         change;
    logic [PW-1:0]                phase;
    logic [PW-1:0]                rmask;
    logic                         tick;
    logic                         at_phase0;
    logic                         bypass;
    logic                         hold_full;
    logic signed [IN_WIDTH-1:0]   hold_data;
    logic signed [IN_WIDTH-1:0]   sample;
    logic                         inject;
    logic signed [ACC_WIDTH-1:0]  comb_x [STAGES+1];
    logic signed [ACC_WIDTH-1:0]  integ [STAGES];
    logic signed [ACC_WIDTH-1:0]  integ_next [STAGES];
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic signed [OUT_WIDTH-1:0]  out_next;
    int                           shift_amt;

    assign change    = VARIABLE && (interpolation != interp_q);
    assign k_cur     = VARIABLE ? k_q : K_FIXED;
    assign bypass    = (k_cur == 5'd0);
    assign rmask     = PW'((1 << k_cur) - 1);
    assign tick      = rate_strobe && !clr;
    assign at_phase0 = tick && (phase == '0);
    assign in_ready  = !hold_full;

    // A rate change is latched here and the filter state is flushed on the following cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            interp_q <= MD'(1);
            k_q      <= 5'd0;
            clr      <= 1'b0;
        end else begin
            clr <= change;
            if (change) begin
                interp_q <= interpolation;
                k_q      <= is_legal_r(interpolation, RMAX) ? 5'(clog2(int'(interpolation))) : 5'd0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (tick) begin
            phase <= (phase == rmask) ? '0 : phase + PW'(1);
        end
    end

    // Holding register first, then a same-cycle strobe, else a zero is injected
    always_comb begin
        sample = '0;
        inject = 1'b0;
        if (hold_full) begin
            sample = hold_data;
        end else if (in_strobe) begin
            sample = in_data;
        end else begin
            inject = at_phase0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (at_phase0 && hold_full) begin
            hold_full <= 1'b0;
        end else if (in_strobe && !hold_full && !at_phase0) begin
            hold_full <= 1'b1;
            hold_data <= in_data;
        end
    end

    assign comb_x[0] = ACC_WIDTH'(sample);

    for (genvar g = 0; g < STAGES; g++) begin : g_comb
        cic_comb_stage #(
            .WIDTH(ACC_WIDTH)
        ) u_comb (
            .clock  (clock),
            .reset_n(reset_n),
            .clear  (clr),
            .enable (at_phase0 && !bypass),
            .x      (comb_x[g]),
            .y      (comb_x[g+1])
        );
    end

    always_comb begin
        integ_next[0] = integ[0] + (at_phase0 ? comb_x[STAGES] : '0);
        for (int i = 1; i < STAGES; i++) begin
            integ_next[i] = integ[i] + integ[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) integ[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < STAGES; i++) integ[i] <= '0;
        end else if (tick && !bypass) begin
            for (int i = 0; i < STAGES; i++) integ[i] <= integ_next[i];
        end
    end

    // Dropping (N-1)*k low bits removes the R^(N-1) DC gain
    always_comb begin
        shift_amt = growth_r(STAGES, 1 << k_cur);
        shifted   = integ_next[STAGES-1] >>> shift_amt;
        if (bypass) begin
            out_next = sample[IN_WIDTH-1 -: OUT_WIDTH];
        end else begin
            out_next = shifted[IN_WIDTH-1 -: OUT_WIDTH];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_strobe <= 1'b0;
            out_data   <= '0;
        end else begin
            out_strobe <= tick;
            if (tick) out_data <= out_next;
        end
    end

`ifdef CIC_INTERP_UNDERRUN_EN
    logic underrun_q;
    logic unused_bits;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            underrun_q <= 1'b0;
        end else if (inject) begin
            underrun_q <= 1'b1;
        end
    end

    assign underrun    = underrun_q;
    assign unused_bits = ^{shifted, sample};
`else
    logic unused_bits;

    assign underrun    = 1'b0;
    assign unused_bits = ^{shifted, sample, inject};
`endif

endmodule

// File: tb/tb_cic_interp_var.sv
// tb/tb_cic_interp_var.sv - scoreboard bench for cic_interp_var (N=3, Rmax=8)
module tb_cic_interp_var;

`ifdef CIC_INTERP_UNDERRUN_EN
    localparam bit UR_EN = 1'b1;
`else
    localparam bit UR_EN = 1'b0;
`endif

    logic               clock = 1'b0;
    logic               reset_n;
    logic [17:0]        interpolation;
    logic               in_strobe;
    logic signed [15:0] in_data;
    logic               in_ready;
    logic               rate_strobe;
    logic               out_strobe;
    logic signed [15:0] out_data;
    logic               underrun;

    typedef struct packed {
        logic        chk;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic [15:0] imp [8] = '{16'd0, 16'd0, 16'd4096, 16'd12288, 16'd12288, 16'd4096, 16'd0, 16'd0};

    always #5 clock = ~clock;

    cic_interp_var #(
        .STAGES       (3),
        .INTERPOLATION(-8),
        .IN_WIDTH     (16),
        .GROWTH       (9),
        .OUT_WIDTH    (16)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .interpolation(interpolation),
        .in_strobe    (in_strobe),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .rate_strobe  (rate_strobe),
        .out_strobe   (out_strobe),
        .out_data     (out_data),
        .underrun     (underrun)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic do_reset(input logic [17:0] r);
        @(negedge clock);
        reset_n = 1'b0; in_strobe = 1'b0; rate_strobe = 1'b0; in_data = '0; interpolation = r;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        sb.delete();
        repeat (3) @(negedge clock);
    endtask

    task automatic tick(input logic signed [15:0] d, input logic strobe, input logic chk, input logic [15:0] e);
        @(negedge clock);
        in_strobe = strobe; in_data = d; rate_strobe = 1'b1;
        sb.push_back('{chk, e});
    endtask

    task automatic idle();
        @(negedge clock);
        in_strobe = 1'b0; rate_strobe = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (out_strobe) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got strobe with data %0d, required no output", out_data);
                end else begin
                    e = sb.pop_front();
                    if (e.chk) check("out_data", 16'(out_data), e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin
        logic first;
        reset_n = 1'b0; interpolation = 18'd1; in_strobe = 1'b0; in_data = '0; rate_strobe = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_in_ready", 16'(in_ready), 16'd1);
        check("rst_out_strobe", 16'(out_strobe), 16'd0);
        check("rst_out_data", 16'(out_data), 16'd0);
        check("rst_underrun", 16'(underrun), 16'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // bypass R=1
        tick(16'sh1234, 1'b1, 1'b1, 16'h1234);
        @(negedge clock);
        check("bypass_strobe", 16'(out_strobe), 16'd1);
        in_strobe = 1'b0; rate_strobe = 1'b0;
        @(negedge clock);
        check("bypass_pulse", 16'(out_strobe), 16'd0);

        // holding register corners at R=1
        @(negedge clock);
        in_strobe = 1'b1; in_data = 16'sh1111; rate_strobe = 1'b0;
        @(negedge clock);
        check("hold_full_ready", 16'(in_ready), 16'd0);
        in_data = 16'sh2222;
        @(negedge clock);
        check("hold_ignore_ready", 16'(in_ready), 16'd0);
        in_strobe = 1'b0; rate_strobe = 1'b1;
        sb.push_back('{1'b1, 16'h1111});
        @(negedge clock);
        check("hold_drained_ready", 16'(in_ready), 16'd1);
        in_strobe = 1'b1; in_data = 16'sh3333;
        sb.push_back('{1'b1, 16'h3333});
        @(negedge clock);
        in_strobe = 1'b0; rate_strobe = 1'b0;
        check("direct_no_load", 16'(in_ready), 16'd1);
        check("direct_no_underrun", 16'(underrun), 16'd0);

        // impulse at R=2
        do_reset(18'd2);
        first = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(first ? 16'sd16384 : 16'sd0, 1'b1, 1'b1, imp[i]);
            if (in_ready) first = 1'b0;
        end
        idle();

        // DC at R=4, then asynchronous reset mid-burst
        do_reset(18'd4);
        for (int i = 0; i < 32; i++) tick(16'sd1000, 1'b1, i >= 16, 16'd1000);
        @(negedge clock);
        check("dc4_underrun", 16'(underrun), 16'd0);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_out_strobe", 16'(out_strobe), 16'd0);
        check("async_rst_out_data", 16'(out_data), 16'd0);
        check("async_rst_in_ready", 16'(in_ready), 16'd1);
        sb.delete();

        // underrun at R=8
        do_reset(18'd8);
        tick(16'sd500, 1'b1, 1'b0, 16'd0);
        for (int i = 1; i < 8; i++) tick(16'sd0, 1'b0, 1'b0, 16'd0);
        tick(16'sd0, 1'b0, 1'b0, 16'd0);
        check("underrun_before", 16'(underrun), 16'd0);
        tick(16'sd0, 1'b0, 1'b0, 16'd0);
        check("underrun_set", 16'(underrun), 16'(UR_EN));
        for (int i = 0; i < 6; i++) tick(16'sd0, 1'b1, 1'b0, 16'd0);
        check("underrun_sticky", 16'(underrun), 16'(UR_EN));
        idle();

        // rate change 4 -> 8
        do_reset(18'd4);
        check("underrun_cleared", 16'(underrun), 16'd0);
        for (int i = 0; i < 22; i++) tick(16'sd1000, 1'b1, 1'b0, 16'd0);
        @(negedge clock);
        interpolation = 18'd8; rate_strobe = 1'b0;
        @(negedge clock);
        rate_strobe = 1'b1;
        @(negedge clock);
        check("clear_tick_ignored", 16'(out_strobe), 16'd0);
        rate_strobe = 1'b0;
        for (int i = 0; i < 48; i++) tick(16'sd1000, 1'b1, (i < 2) || (i >= 32), (i < 2) ? 16'd0 : 16'd1000);
        idle();
        @(negedge clock);
        check("sb_empty", 16'(sb.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
